// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller for the RV32I execute stage: accepts one op at a time,
// resolves it against registered operands, then drives the fetch redirect and a multi-cycle flush.

module branch_ctrl #(
    parameter int n            = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         br_valid,
    output logic         br_ready,
    input  logic [2:0]   funct3,
    input  logic         is_jal,
    input  logic         is_jalr,
    input  logic [n-1:0] pc,
    input  logic [n-1:0] imm,
    input  logic [n-1:0] rs1_val,
    input  logic [n-1:0] rs2_val,
    output logic         done,
    output logic         taken,
    output logic [n-1:0] link,
    output logic         redirect,
    output logic [n-1:0] redirect_pc,
    output logic         flush,
    output logic         err,
    output logic [n-1:0] branch_count,
    output logic [n-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [2:0]   FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [n-1:0] JALR_MASK  = ~(n'(1'b1));
    localparam logic [n-1:0] LINK_STEP  = n'(3'd4);
    localparam logic [n-1:0] ONE        = n'(1'b1);

    state_t       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] imm_q, imm_d;
    logic [n-1:0] rs1_q, rs1_d;
    logic [n-1:0] rs2_q, rs2_d;
    logic [2:0]   funct3_q, funct3_d;
    logic         is_jal_q, is_jal_d;
    logic         is_jalr_q, is_jalr_d;
    logic         done_q, done_d;
    logic         taken_q, taken_d;
    logic         err_q, err_d;
    logic         redirect_q, redirect_d;
    logic         flush_q, flush_d;
    logic [n-1:0] link_q, link_d;
    logic [n-1:0] redirect_pc_q, redirect_pc_d;
    logic [n-1:0] branch_count_q, branch_count_d;
    logic [n-1:0] taken_count_q, taken_count_d;
    logic [2:0]   flush_cnt_q, flush_cnt_d;

    logic         cmp_eq, cmp_lt, cmp_ltu;
    logic         cond_met, funct3_legal, is_jump, would_take;
    logic         res_err, res_taken;
    logic [n-1:0] target;

    // Flag set, target and taken/err decision from the registered op.
    always_comb begin
        cmp_eq       = (rs1_q == rs2_q);
        cmp_lt       = ($signed(rs1_q) < $signed(rs2_q));
        cmp_ltu      = (rs1_q < rs2_q);
        cond_met     = 1'b0;
        funct3_legal = 1'b1;
        case (funct3_q)
            3'b000:  cond_met = cmp_eq;
            3'b001:  cond_met = ~cmp_eq;
            3'b100:  cond_met = cmp_lt;
            3'b101:  cond_met = ~cmp_lt;
            3'b110:  cond_met = cmp_ltu;
            3'b111:  cond_met = ~cmp_ltu;
            default: begin
                cond_met     = 1'b0;
                funct3_legal = 1'b0;
            end
        endcase
        is_jump = is_jal_q | is_jalr_q;
        if (is_jalr_q) begin
            target = (rs1_q + imm_q) & JALR_MASK;
        end else begin
            target = pc_q + imm_q;
        end
        would_take = is_jump | cond_met;
        // JALR only strips bit 0; bit-1 alignment is policed on pc-relative targets.
        res_err   = (~is_jump & ~funct3_legal) | (would_take & ~is_jalr_q & target[1]);
        res_taken = would_take & ~res_err;
    end

    // Next-state, operand capture and registered-output computation.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imm_d          = imm_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        funct3_d       = funct3_q;
        is_jal_d       = is_jal_q;
        is_jalr_d      = is_jalr_q;
        done_d         = 1'b0;
        taken_d        = 1'b0;
        err_d          = 1'b0;
        redirect_d     = 1'b0;
        flush_d        = 1'b0;
        link_d         = link_q;
        redirect_pc_d  = redirect_pc_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        flush_cnt_d    = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    pc_d      = pc;
                    imm_d     = imm;
                    rs1_d     = rs1_val;
                    rs2_d     = rs2_val;
                    funct3_d  = funct3;
                    is_jal_d  = is_jal;
                    is_jalr_d = is_jalr;
                    state_d   = RESOLVE;
                end else begin
                    state_d   = IDLE;
                end
            end
            RESOLVE: begin
                done_d         = 1'b1;
                taken_d        = res_taken;
                err_d          = res_err;
                link_d         = pc_q + LINK_STEP;
                branch_count_d = branch_count_q + ONE;
                if (res_taken) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = target;
                    taken_count_d = taken_count_q + ONE;
                    flush_d       = 1'b1;
                    state_d       = REDIRECT;
                end else begin
                    state_d       = IDLE;
                end
            end
            REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    flush_d     = 1'b1;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = FLUSH;
                end else begin
                    state_d     = IDLE;
                end
            end
            FLUSH: begin
                // Counter holds the flush cycles still owed, including this one.
                if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    flush_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and output registers with asynchronous abort on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            imm_q          <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            funct3_q       <= 3'd0;
            is_jal_q       <= 1'b0;
            is_jalr_q      <= 1'b0;
            done_q         <= 1'b0;
            taken_q        <= 1'b0;
            err_q          <= 1'b0;
            redirect_q     <= 1'b0;
            flush_q        <= 1'b0;
            link_q         <= '0;
            redirect_pc_q  <= '0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
            flush_cnt_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            imm_q          <= imm_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            funct3_q       <= funct3_d;
            is_jal_q       <= is_jal_d;
            is_jalr_q      <= is_jalr_d;
            done_q         <= done_d;
            taken_q        <= taken_d;
            err_q          <= err_d;
            redirect_q     <= redirect_d;
            flush_q        <= flush_d;
            link_q         <= link_d;
            redirect_pc_q  <= redirect_pc_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign br_ready     = (state_q == IDLE);
    assign done         = done_q;
    assign taken        = taken_q;
    assign err          = err_q;
    assign link         = link_q;
    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign flush        = flush_q;
    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: a reference model pushes expected resolutions into a
// scoreboard queue at issue time; a monitor pops and compares them when done pulses.

module tb_branch_ctrl;

    localparam int N  = 32;
    localparam int FC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          br_valid;
    logic          br_ready;
    logic [2:0]    funct3;
    logic          is_jal;
    logic          is_jalr;
    logic [N-1:0]  pc;
    logic [N-1:0]  imm;
    logic [N-1:0]  rs1_val;
    logic [N-1:0]  rs2_val;
    logic          done;
    logic          taken;
    logic [N-1:0]  link;
    logic          redirect;
    logic [N-1:0]  redirect_pc;
    logic          flush;
    logic          err;
    logic [N-1:0]  branch_count;
    logic [N-1:0]  taken_count;

    typedef struct {
        logic        tk;
        logic        er;
        logic [31:0] lnk;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] bc_m     = 32'd0;
    logic [31:0] tc_m     = 32'd0;

    branch_ctrl #(.n(N), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
        .funct3(funct3), .is_jal(is_jal), .is_jalr(is_jalr), .pc(pc), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .done(done), .taken(taken), .link(link),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .err(err),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict the resolution, push it, and complete the handshake (optionally keeping br_valid up).
    task automatic issue(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output logic tk);
        exp_t        e;
        logic [31:0] tgt;
        logic        cond, legal, jump, wt, er;
        jump  = jal | jalr;
        tgt   = jalr ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
        legal = 1'b1;
        cond  = 1'b0;
        case (f3)
            3'd0:    cond = (a == b);
            3'd1:    cond = (a != b);
            3'd4:    cond = ($signed(a) < $signed(b));
            3'd5:    cond = ($signed(a) >= $signed(b));
            3'd6:    cond = (a < b);
            3'd7:    cond = (a >= b);
            default: legal = 1'b0;
        endcase
        wt = jump | cond;
        er = (!jump && !legal) || (wt && !jalr && tgt[1]);
        tk = wt && !er;
        bc_m = bc_m + 32'd1;
        if (tk) tc_m = tc_m + 32'd1;
        e.tk = tk; e.er = er; e.lnk = p + 32'd4; e.tgt = tgt; e.bc = bc_m; e.tc = tc_m;
        sb_q.push_back(e);
        funct3 = f3; is_jal = jal; is_jalr = jalr; pc = p; imm = im; rs1_val = a; rs2_val = b;
        br_valid = 1'b1;
        for (int i = 0; i < 50 && !br_ready; i++) @(negedge clk);
        if (!br_ready) begin
            check_val("handshake_timeout", 32'd0, 32'd1);
            br_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) br_valid = 1'b0;
    endtask

    // Measure done latency, flush length and time back to ready after a handshake.
    task automatic observe(input logic tk);
        int k = 0;
        int k_done = -1;
        int nfl = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (done && k_done < 0) k_done = k;
            if (flush) nfl++;
            if (br_ready) break;
        end
        check_val("done_latency", 32'(k_done), 32'd2);
        check_val("flush_cycles", 32'(nfl), tk ? 32'(FC) : 32'd0);
        check_val("ready_return", 32'(k), tk ? 32'(2 + FC) : 32'd2);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic jal, input logic jalr,
                          input logic [31:0] p, input logic [31:0] im,
                          input logic [31:0] a, input logic [31:0] b);
        logic tk;
        @(negedge clk);
        issue(f3, jal, jalr, p, im, a, b, 1'b0, tk);
        observe(tk);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending prediction.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("taken", {31'd0, taken}, {31'd0, mon_e.tk});
                check_val("err", {31'd0, err}, {31'd0, mon_e.er});
                check_val("redirect", {31'd0, redirect}, {31'd0, mon_e.tk});
                check_val("flush_at_done", {31'd0, flush}, {31'd0, mon_e.tk});
                check_val("link", link, mon_e.lnk);
                if (mon_e.tk) check_val("redirect_pc", redirect_pc, mon_e.tgt);
                check_val("branch_count", branch_count, mon_e.bc);
                check_val("taken_count", taken_count, mon_e.tc);
            end
        end
        if (!reset && !done && (redirect || err))
            check_val("stray_pulse", {30'd0, redirect, err}, 32'd0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        tk;
        logic [2:0]  legal_f3 [6];
        legal_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        reset = 1'b1; br_valid = 1'b0; funct3 = 3'd0; is_jal = 1'b0; is_jalr = 1'b0;
        pc = 32'd0; imm = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, br_ready}, 32'd1);
        check_val("rst_pulses", {28'd0, done, taken, redirect, err}, 32'd0);
        check_val("rst_flush", {31'd0, flush}, 32'd0);
        check_val("rst_counts", branch_count | taken_count | link | redirect_pc, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(3'd0, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5);                  // beq taken
        run_op(3'd4, 1'b0, 1'b0, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);          // blt -1<1
        run_op(3'd6, 1'b0, 1'b0, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);          // bltu not taken
        run_op(3'd0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h203, 32'd0);                 // jalr clears bit0
        run_op(3'd0, 1'b0, 1'b1, 32'h300, 32'h1, 32'h201, 32'd0);                 // jalr 0x202
        run_op(3'd0, 1'b1, 1'b0, 32'h100, 32'h6, 32'd0, 32'd0);                   // jal misaligned
        run_op(3'd2, 1'b0, 1'b0, 32'h400, 32'h10, 32'd1, 32'd1);                  // illegal funct3
        run_op(3'd3, 1'b0, 1'b0, 32'h400, 32'h10, 32'd1, 32'd2);                  // illegal funct3
        run_op(3'd1, 1'b0, 1'b0, 32'h500, 32'h8, 32'd7, 32'd7);                   // bne not taken
        run_op(3'd5, 1'b0, 1'b0, 32'h500, 32'h8, 32'd3, 32'hFFFF_FFFE);           // bge 3>=-2
        run_op(3'd7, 1'b0, 1'b0, 32'h500, 32'h8, 32'd3, 32'hFFFF_FFFE);           // bgeu not taken
        run_op(3'd6, 1'b1, 1'b1, 32'h600, 32'h100, 32'h1000, 32'd0);              // jalr wins
        run_op(3'd0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'd1, 32'd1);             // wrap target/link

        // Back-to-back: br_valid stays high; the second op must wait for the first IDLE.
        @(negedge clk);
        issue(3'd0, 1'b0, 1'b0, 32'h700, 32'h10, 32'd9, 32'd9, 1'b1, tk);
        funct3 = 3'd6; pc = 32'h800; imm = 32'h20; rs1_val = 32'd1; rs2_val = 32'd2;
        begin
            int k = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                k++;
                if (br_ready) break;
            end
            check_val("b2b_accept_gap", 32'(k), 32'(2 + FC));
        end
        issue(3'd6, 1'b0, 1'b0, 32'h800, 32'h20, 32'd1, 32'd2, 1'b0, tk);
        observe(tk);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b, im, p;
            logic        jl;
            a  = 32'($urandom_range(0, 6)) - 32'd3;
            b  = 32'($urandom_range(0, 6)) - 32'd3;
            im = 32'($urandom_range(0, 511)) << 1;
            p  = {$urandom_range(0, 65535), 2'b00};
            jl = ($urandom_range(0, 3) == 0);
            run_op(legal_f3[$urandom_range(0, 5)], jl, 1'b0, p, im, a, b);
        end

        // Reset in the middle of a flush aborts everything.
        @(negedge clk);
        issue(3'd0, 1'b0, 1'b0, 32'h900, 32'h40, 32'd4, 32'd4, 1'b0, tk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (flush && !redirect) break;
        end
        check_val("reach_flush", {31'd0, flush}, 32'd1);
        reset = 1'b1;
        #1;
        bc_m = 32'd0;
        tc_m = 32'd0;
        check_val("abort_flush", {31'd0, flush}, 32'd0);
        check_val("abort_pulses", {29'd0, done, redirect, err}, 32'd0);
        check_val("abort_ready", {31'd0, br_ready}, 32'd1);
        check_val("abort_counts", branch_count | taken_count, 32'd0);
        check_val("abort_sb", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check_val("abort_ready_hold", {31'd0, br_ready}, 32'd1);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        run_op(3'd1, 1'b0, 1'b0, 32'hA00, 32'h14, 32'd1, 32'd2);

        repeat (4) @(negedge clk);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch resolution controller for the RV32I execute stage. It accepts one branch or jump op at a time through a valid/ready handshake, registers the operands, and evaluates the eq/ne/lt/ge flag set in both signed and unsigned form. It then decides taken or not-taken, computes the target and link address, and sequences the front-end redirect and a multi-cycle pipeline flush. It also keeps branch and taken counters for performance monitoring.

Parameters:
n, 32, datapath width (PC, operands, immediate, counters)
FLUSH_CYCLES, 2, cycles flush is held high after a taken redirect (legal range 1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
br_valid  input  1  branch op presented
br_ready  output  1  controller can accept op (high only in IDLE)
funct3  input  3  B-type funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
is_jal  input  1  op is JAL (unconditional, target pc+imm)
is_jalr  input  1  op is JALR (unconditional, target (rs1+imm)&~1)
pc  input  n  PC of the op
imm  input  n  sign-extended immediate
rs1_val  input  n  operand A
rs2_val  input  n  operand B
done  output  1  one-cycle pulse: op resolved
taken  output  1  resolution result, valid while done=1
link  output  n  pc+4, valid while done=1
redirect  output  1  one-cycle pulse to fetch
redirect_pc  output  n  new fetch PC, valid while redirect=1
flush  output  1  squash younger pipeline stages
err  output  1  one-cycle pulse with done: illegal funct3 or misaligned target
branch_count  output  n  ops resolved since reset (wraps)
taken_count  output  n  ops redirected since reset (wraps)

Behaviour:
- Reset (async, any state): state=IDLE; done, taken, redirect, flush, err = 0; link, redirect_pc, both counters = 0. br_ready = 1 in IDLE, including during reset.
- FSM states: IDLE, RESOLVE, REDIRECT, FLUSH.
- IDLE: br_ready=1. On br_valid at edge T, register pc, imm, rs1_val, rs2_val, funct3, is_jal and is_jalr, then go to RESOLVE. With br_valid=0, stay in IDLE.
- RESOLVE (cycle T+1), br_ready=0:
  - Compute eq, ne, lt/ge signed, and ltu/geu unsigned from the registered operands.
  - is_jal or is_jalr forces the op unconditional; if both are set, is_jalr wins.
  - Target is pc+imm, or (rs1+imm)&~1 for JALR. All arithmetic is modulo 2^n.
  - At the edge ending RESOLVE, register done=1, taken, link=pc+4 and err for one cycle (cycle T+2). branch_count increments by 1 at the same edge.
- Illegal funct3 (010, 011) with neither jump flag set: taken=0, err=1, no redirect.
- Misaligned target (bit 1 set) when the op would be taken: taken=0, err=1, no redirect, taken_count unchanged.
- Taken and legal:
  - redirect=1 and redirect_pc=target in cycle T+2; taken_count increments at the same edge.
  - Next state is REDIRECT, which lasts one cycle. From REDIRECT go to FLUSH if FLUSH_CYCLES>1, otherwise to IDLE.
  - flush=1 from cycle T+2 through T+1+FLUSH_CYCLES inclusive.
  - A down-counter in FLUSH returns to IDLE after FLUSH_CYCLES-1 cycles.
- Not taken or err: next state is IDLE, so br_ready=1 in cycle T+2 with no flush.
- Throughput: a not-taken op needs 2 cycles; a taken op needs 2+FLUSH_CYCLES cycles.
- br_valid while br_ready=0 is ignored. The requester must hold the op until the handshake completes.
- Counters wrap from 2^n-1 to 0. done, redirect and err are never asserted for more than one cycle per op.
- Reset asserted mid-RESOLVE, REDIRECT or FLUSH aborts the op immediately. No pulse is produced after reset deasserts.

Test Plan:
- Reset then beq, rs1=rs2=5, pc=0x100, imm=0x20 -> done at T+2, taken=1, redirect_pc=0x120, link=0x104, flush high 2 cycles, br_ready back at T+4, both counters=1.
- blt rs1=0xFFFFFFFF, rs2=1 -> taken (signed -1<1). bltu with the same operands -> not taken, no flush, br_ready high at T+2, taken_count unchanged.
- JALR rs1=0x203, imm=0 -> redirect_pc=0x202 bit0 cleared, taken=1. JALR rs1=0x201, imm=1 -> target 0x202, no err. JAL pc=0x100, imm=0x6 -> target 0x106 misaligned, err=1, taken=0, no redirect.
- funct3=010 -> err=1, taken=0, done=1, branch_count increments, no flush.
- Back-to-back br_valid held continuously with FLUSH_CYCLES=3 -> second op accepted only at first IDLE after 3 flush cycles. br_valid while busy is ignored.
- Assert reset during FLUSH -> flush, redirect and counters drop to 0 immediately, state IDLE, br_ready=1, no stray done after release.
